// File: rtl/wb_pkg.sv
// Package: wb_pkg
// Shared constants and types for the write-back stage: data width,
// register-address width, register count, the hard-wired zero register
// and the default starvation limit for the multi-cycle source.
// The optional forwarding outputs of writeback_arbiter are enabled by
// defining the macro WB_BYPASS_EN.
package wb_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int STARVE_LIMIT = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // Which execute source owns the write port this cycle.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_e;

    // Counter width able to hold the values 0..limit inclusive.
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Module: wb_scoreboard
// Per-register busy scoreboard. A register becomes busy when an instruction
// writing it is dispatched and becomes free on the edge its result is
// written into the register bank. Register 0 is never busy.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   commit_en    register bank is storing commit_rd on this edge
//   commit_rd    register being stored
//   issue_valid  issue stage dispatches an instruction writing issue_rd
//   issue_rd     destination of the dispatched instruction
//   rs1, rs2     source registers looked up for decode
//   rs1_busy     busy[rs1] (combinational)
//   rs2_busy     busy[rs2] (combinational)
//   rd_busy      busy[issue_rd] (combinational)
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      commit_en,
    input  reg_addr_t commit_rd,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Clear is applied before set so a register that commits and is
    // re-issued on the same edge stays busy for the new producer.
    always_comb begin
        // NOTE: start from the held value so every path assigns busy_next and no latch is inferred.
        busy_next = busy;
        if (commit_en) begin
            busy_next[commit_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != REG_ZERO)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is 32 flops, not a RAM macro, so an async clear is cheap and guarantees no stale hazards after reset.
            busy <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
    assign rd_busy  = busy[issue_rd];

endmodule

// File: rtl/writeback_arbiter.sv
// Module: writeback_arbiter
// Write-back stage in front of the 32x32 register bank write port.
// Arbitrates between a single-cycle source A (ALU) and a multi-cycle source
// B (load/mul). A normally wins; B wins when A is idle or after B has lost
// STARVE_LIMIT consecutive cycles. The winner is registered and presented
// to the bank one cycle later. A busy scoreboard lets issue logic stall on
// pending destinations.
// Optional feature: define WB_BYPASS_EN to add same-cycle forwarding of the
// committing value to decode (rsN_fwd_hit / rsN_fwd_value).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   a_valid/a_ready       source A handshake; a_rd, a_data its result
//   b_valid/b_ready       source B handshake; b_rd, b_data its result
//   issue_valid/issue_rd  dispatch of an instruction writing issue_rd
//   rs1, rs2              decode source registers
//   rs1_busy, rs2_busy    source has a result in flight
//   rd_busy               issue_rd already pending
//   rsN_fwd_hit/value     (WB_BYPASS_EN) committing value matches rsN
//   reg_write, rd, rd_value  register bank write port
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
`ifdef WB_BYPASS_EN
    output logic            rs1_fwd_hit,
    output logic            rs2_fwd_hit,
    output logic [XLEN-1:0] rs1_fwd_value,
    output logic [XLEN-1:0] rs2_fwd_value,
`endif
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_value
);

    localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    wb_src_e          win_src;
    logic             accept;
    reg_addr_t        win_rd;
    logic [XLEN-1:0]  win_data;
    logic             sb_rs1_busy;
    logic             sb_rs2_busy;

    // ---------------- arbitration ----------------
    // Ready depends only on the competing valids and the starvation
    // counter; the output register always accepts, so there is no
    // backpressure path from the bank.
    always_comb begin
        win_src = SRC_A;
        if (b_valid && (!a_valid || (starve_cnt == CNT_MAX))) begin
            win_src = SRC_B;
        end
    end

    assign b_ready  = (win_src == SRC_B);
    assign a_ready  = !b_ready;
    assign accept   = b_ready || a_valid;
    assign win_rd   = b_ready ? b_rd : a_rd;
    assign win_data = b_ready ? b_data : a_data;

    // ---------------- starvation counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (b_valid && !b_ready) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // ---------------- output register ----------------
    // Results to x0 are consumed but never strobed into the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write <= 1'b0;
            rd        <= REG_ZERO;
            rd_value  <= '0;
        end else if (accept) begin
            reg_write <= (win_rd != REG_ZERO);
            rd        <= win_rd;
            rd_value  <= win_data;
        end else begin
            reg_write <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    // The bank stores on the edge where reg_write is high, which is the
    // same edge that frees the register here.
    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .commit_en   (reg_write),
        .commit_rd   (rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (sb_rs1_busy),
        .rs2_busy    (sb_rs2_busy),
        .rd_busy     (rd_busy)
    );

`ifdef WB_BYPASS_EN
    // Decode may take the committing value directly, so the source is not
    // reported busy during its commit cycle.
    assign rs1_fwd_hit   = reg_write && (rd == rs1) && (rs1 != REG_ZERO);
    assign rs2_fwd_hit   = reg_write && (rd == rs2) && (rs2 != REG_ZERO);
    assign rs1_fwd_value = rd_value;
    assign rs2_fwd_value = rd_value;
    assign rs1_busy      = sb_rs1_busy && !rs1_fwd_hit;
    assign rs2_busy      = sb_rs2_busy && !rs2_fwd_hit;
`else
    assign rs1_busy = sb_rs1_busy;
    assign rs2_busy = sb_rs2_busy;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench: tb_writeback_arbiter
// Directed and randomized stimulus against a behavioural model of the
// write-back stage (grant rule, one-cycle result register, busy set per
// register). Build with WB_BYPASS_EN defined to cover the forwarding outputs.
module tb_writeback_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, issue_valid;
    logic         a_ready, b_ready;
    logic [4:0]   a_rd, b_rd, issue_rd, rs1, rs2;
    logic [W-1:0] a_data, b_data;
    logic         rs1_busy, rs2_busy, rd_busy;
    logic         reg_write;
    logic [4:0]   rd;
    logic [W-1:0] rd_value;
`ifdef WB_BYPASS_EN
    logic         rs1_fwd_hit, rs2_fwd_hit;
    logic [W-1:0] rs1_fwd_value, rs2_fwd_value;
`endif

    always #5 clk = ~clk;

    writeback_arbiter #(.XLEN(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
`ifdef WB_BYPASS_EN
        .rs1_fwd_hit   (rs1_fwd_hit),
        .rs2_fwd_hit   (rs2_fwd_hit),
        .rs1_fwd_value (rs1_fwd_value),
        .rs2_fwd_value (rs2_fwd_value),
`endif
        .reg_write   (reg_write),
        .rd          (rd),
        .rd_value    (rd_value)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what the bank will be told next, how many
    // consecutive cycles B has lost, and which registers are pending.
    bit           m_wr;
    logic [4:0]   m_rd;
    logic [W-1:0] m_val;
    int           m_losses;
    bit           m_busy [32];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr     = 1'b0;
        m_rd     = 5'd0;
        m_val    = '0;
        m_losses = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    function automatic bit exp_hit(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        return m_wr && (m_rd == rs) && (rs != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the model
    // on the edge, then check the registered write port just after it.
    task automatic cycle();
        bit b_wins;
        @(negedge clk);
        b_wins = b_valid && (!a_valid || m_losses >= LIMIT);
        check("a_ready", W'(a_ready), W'(!b_wins));
        check("b_ready", W'(b_ready), W'(b_wins));
        check("rs1_busy", W'(rs1_busy), W'(m_busy[rs1] && !exp_hit(rs1)));
        check("rs2_busy", W'(rs2_busy), W'(m_busy[rs2] && !exp_hit(rs2)));
        check("rd_busy", W'(rd_busy), W'(m_busy[issue_rd]));
`ifdef WB_BYPASS_EN
        check("rs1_fwd_hit", W'(rs1_fwd_hit), W'(exp_hit(rs1)));
        check("rs2_fwd_hit", W'(rs2_fwd_hit), W'(exp_hit(rs2)));
        check("rs1_fwd_value", rs1_fwd_value, m_val);
        check("rs2_fwd_value", rs2_fwd_value, m_val);
`endif
        @(posedge clk);
        if (m_wr) m_busy[m_rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        if (b_wins) begin
            m_wr = (b_rd != 5'd0); m_rd = b_rd; m_val = b_data;
        end else if (a_valid) begin
            m_wr = (a_rd != 5'd0); m_rd = a_rd; m_val = a_data;
        end else begin
            m_wr = 1'b0;
        end
        if (b_valid && !b_wins) m_losses = (m_losses + 1 > LIMIT) ? LIMIT : m_losses + 1;
        else m_losses = 0;
        #1;
        check("reg_write", W'(reg_write), W'(m_wr));
        check("rd", W'(rd), W'(m_rd));
        check("rd_value", rd_value, m_val);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; issue_valid = 0;
        a_rd = 0; b_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        a_data = '0; b_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int a_wins;
        int b_wins;

        // ---- reset state, before any clock edge ----
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        check("rst_reg_write", W'(reg_write), W'(0));
        check("rst_rd", W'(rd), W'(0));
        check("rst_rd_value", rd_value, W'(0));
        for (int r = 0; r < 32; r += 5) begin
            rs1 = 5'(r); #1;
            check("rst_busy", W'(rs1_busy), W'(0));
        end
        rs1 = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- 1: A only writes rd=5 ----
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        check("t1_reg_write", W'(reg_write), W'(1));
        check("t1_rd", W'(rd), W'(5));
        check("t1_rd_value", rd_value, 32'hDEAD_BEEF);
        cycle();
        check("t1_no_write", W'(reg_write), W'(0));

        // ---- 2: A and B both valid every cycle -> B gets 1 of 5 ----
        a_wins = 0; b_wins = 0;
        for (int i = 0; i < 15; i++) begin
            a_valid = 1; a_rd = 5'd10; a_data = 32'hAAAA_0000 + W'(i);
            b_valid = 1; b_rd = 5'd11; b_data = 32'hBBBB_0000 + W'(i);
            cycle();
            if (rd_value[31:16] == 16'hBBBB) b_wins++;
            else if (rd_value[31:16] == 16'hAAAA) a_wins++;
        end
        check("t2_b_grants", W'(b_wins), W'(3));
        check("t2_a_grants", W'(a_wins), W'(12));
        idle_inputs();
        cycle();

        // ---- 3: result to x0 is consumed but not written ----
        a_valid = 1; a_rd = 5'd0; a_data = 32'h0000_1234;
        #1;
        check("t3_a_ready", W'(a_ready), W'(1));
        cycle();
        idle_inputs();
        check("t3_no_write", W'(reg_write), W'(0));
        check("t3_rd", W'(rd), W'(0));

        // ---- 4: RAW on r7 through commit ----
        issue_valid = 1; issue_rd = 5'd7;
        cycle();
        issue_valid = 0; rs1 = 5'd7;
        cycle();
        check("t4_pending", W'(rs1_busy), W'(1));
        a_valid = 1; a_rd = 5'd7; a_data = 32'h0000_0077;
        cycle();
        a_valid = 0;
        #1;
        check("t4_commit_write", W'(reg_write), W'(1));
`ifdef WB_BYPASS_EN
        check("t4_commit_hit", W'(rs1_fwd_hit), W'(1));
        check("t4_commit_fwd", rs1_fwd_value, 32'h0000_0077);
        check("t4_commit_busy", W'(rs1_busy), W'(0));
`else
        check("t4_commit_busy", W'(rs1_busy), W'(1));
`endif
        cycle();
        check("t4_after_busy", W'(rs1_busy), W'(0));
        idle_inputs();

        // ---- 5: commit r9 and re-issue r9 on the same edge ----
        issue_valid = 1; issue_rd = 5'd9;
        cycle();
        issue_valid = 0;
        a_valid = 1; a_rd = 5'd9; a_data = 32'h0000_0099;
        cycle();
        a_valid = 0; issue_valid = 1; issue_rd = 5'd9;
        cycle();
        issue_valid = 0;
        #1;
        check("t5_rd_busy", W'(rd_busy), W'(1));
        cycle();
        check("t5_rd_busy_hold", W'(rd_busy), W'(1));
        idle_inputs();

        // ---- 6: reset while B is starving and a write is pending ----
        issue_valid = 1; issue_rd = 5'd12;
        cycle();
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_rd = 5'd3; a_data = 32'h3300_0000 + W'(i);
            b_valid = 1; b_rd = 5'd4; b_data = 32'h4400_0000 + W'(i);
            cycle();
        end
        check("t6_pre_write", W'(reg_write), W'(1));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        rs1 = 5'd12; issue_rd = 5'd12;
        #1;
        check("t6_reg_write", W'(reg_write), W'(0));
        check("t6_rd", W'(rd), W'(0));
        check("t6_rd_value", rd_value, W'(0));
        check("t6_rs1_busy", W'(rs1_busy), W'(0));
        check("t6_rd_busy", W'(rd_busy), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        // B must wait the full limit again: the counter was cleared.
        b_wins = 0;
        for (int i = 0; i < LIMIT + 1; i++) begin
            cycle();
            if (i < LIMIT && rd_value[31:24] == 8'h44) b_wins++;
        end
        check("t6_cnt_cleared", W'(b_wins), W'(0));
        check("t6_b_after_limit", rd_value, 32'h4400_0002);
        idle_inputs();
        cycle();

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            a_valid     = ($urandom_range(0, 3) != 0);
            b_valid     = ($urandom_range(0, 2) != 0);
            a_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_data      = $urandom;
            b_data      = $urandom;
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd    = 5'($urandom_range(0, 31));
            rs1         = ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31));
            rs2         = 5'($urandom_range(0, 31));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
